// File: rtl/perf_pkg.sv
// Shared state encoding, legal parameter limits and index-width helper for the
// performance counter bank.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } perf_state_e;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 15;
  localparam int CNT_W_MIN  = 8;
  localparam int CNT_W_MAX  = 64;

  // One index per event channel plus the cycle counter at index 0.
  function automatic int perf_idx_w(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Single CNT_W event counter with clear, wrap/saturate mode and, when
// PERF_OVF_EN is defined, a sticky overflow flag.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_nxt
`ifdef PERF_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full_s;

  assign full_s  = &cnt_q;
  // The next-state value equals the held count whenever inc and clr are low,
  // so the parent can read it both before and after the freeze.
  assign cnt_nxt = cnt_d;

  // Next count: clear wins over increment; SAT holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc) begin
      if (SAT && full_s) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef PERF_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Sticky flag: any increment attempted at all-ones, either mode.
  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (inc && full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle + per-channel event counters that freeze on halt and stream out over a
// valid/ready port. PERF_OVF_EN adds sticky per-counter overflow flags.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  CNT_W  = 32,
  parameter bit  SAT    = 1'b0,
  localparam int IDX_W  = perf_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ev,
  input  logic              halt,
  input  logic              clr,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [CNT_W-1:0]  dump_data,
  output logic              done
`ifdef PERF_OVF_EN
  ,
  output logic [NUM_CH:0]   ovf
`endif
);

  perf_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             done_q;
  logic [CNT_W-1:0] data_q;

  logic             run_s;
  logic             cnt_clr_s;
  logic             last_s;
  logic [NUM_CH:0]  inc_s;
  logic [IDX_W:0]   sel_s;
  logic [CNT_W-1:0] sel_data_s;
  logic [CNT_W-1:0] cnt_nxt_s [NUM_CH+1];

  // Counters only move in RUN; DUMP and DONE freeze them.
  assign run_s     = (state_q == ST_RUN);
  assign cnt_clr_s = run_s && clr;
  assign inc_s     = (run_s && en) ? {ev, 1'b1} : {(NUM_CH+1){1'b0}};
  assign last_s    = (idx_q == IDX_W'(NUM_CH));

  for (genvar g = 0; g <= NUM_CH; g++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W),
      .SAT   (SAT)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_s[g]),
      .clr     (cnt_clr_s),
      .cnt_nxt (cnt_nxt_s[g])
`ifdef PERF_OVF_EN
      ,
      .ovf     (ovf[g])
`endif
    );
  end

  // The first beat loads the cycle counter including the halt cycle.
  assign sel_s = run_s ? {(IDX_W+1){1'b0}} : ({1'b0, idx_q} + (IDX_W+1)'(1));

  // Select the counter that feeds the next dump beat.
  always_comb begin
    sel_data_s = {CNT_W{1'b0}};
    for (int k = 0; k <= NUM_CH; k++) begin
      sel_data_s = (sel_s == (IDX_W+1)'(k)) ? cnt_nxt_s[k] : sel_data_s;
    end
  end

  // Control FSM with registered dump port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      idx_q   <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt && en) begin
            state_q <= ST_DUMP;
            valid_q <= 1'b1;
            idx_q   <= {IDX_W{1'b0}};
            data_q  <= sel_data_s;
          end
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (last_s) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_q + IDX_W'(1);
              data_q <= sel_data_s;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_RUN;
          idx_q   <= {IDX_W{1'b0}};
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          data_q  <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign dump_valid = valid_q;
  assign dump_idx   = idx_q;
  assign dump_data  = data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: one 32-bit wrapping bank plus 8-bit wrap and saturate banks
// sharing the same stimulus.
module tb_perf_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, halt, clr, dump_ready;
  logic [3:0] ev;

  logic        m_valid, w0_valid, w1_valid;
  logic        m_done, w0_done, w1_done;
  logic [2:0]  m_idx, w0_idx, w1_idx;
  logic [31:0] m_data;
  logic [7:0]  w0_data, w1_data;
`ifdef PERF_OVF_EN
  logic [4:0]  m_ovf, w0_ovf, w1_ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  logic [63:0] cap_m  [5];
  logic [63:0] cap_w0 [5];
  logic [63:0] cap_w1 [5];

  perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .SAT(1'b0)) u_main (
    .clk(clk), .rst(rst), .en(en), .ev(ev), .halt(halt), .clr(clr),
    .dump_ready(dump_ready), .dump_valid(m_valid), .dump_idx(m_idx),
    .dump_data(m_data), .done(m_done)
`ifdef PERF_OVF_EN
    , .ovf(m_ovf)
`endif
  );

  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT(1'b0)) u_w0 (
    .clk(clk), .rst(rst), .en(en), .ev(ev), .halt(halt), .clr(clr),
    .dump_ready(dump_ready), .dump_valid(w0_valid), .dump_idx(w0_idx),
    .dump_data(w0_data), .done(w0_done)
`ifdef PERF_OVF_EN
    , .ovf(w0_ovf)
`endif
  );

  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .ev(ev), .halt(halt), .clr(clr),
    .dump_ready(dump_ready), .dump_valid(w1_valid), .dump_idx(w1_idx),
    .dump_data(w1_data), .done(w1_done)
`ifdef PERF_OVF_EN
    , .ovf(w1_ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic [3:0] v, input logic h, input logic c);
    en = e; ev = v; halt = h; clr = c;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ev = 4'd0; halt = 1'b0; clr = 1'b0; dump_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic acc();
    if (m_valid && dump_ready) beats++;
    tick();
  endtask

  // Called right after the halt edge; drains all five beats with ready high.
  task automatic capture(input string tag);
    halt = 1'b0; clr = 1'b0; dump_ready = 1'b1;
    chk({tag, "_valid"}, 64'({m_valid, w0_valid, w1_valid}), 64'd7);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_idx%0d", tag, k), 64'({m_idx, w0_idx, w1_idx}),
          64'({3'(k), 3'(k), 3'(k)}));
      cap_m[k]  = 64'(m_data);
      cap_w0[k] = 64'(w0_data);
      cap_w1[k] = 64'(w1_data);
      tick();
    end
    dump_ready = 1'b0;
    chk({tag, "_done"}, 64'({m_done, w0_done, w1_done, m_valid, w0_valid, w1_valid}), 64'h38);
  endtask

  task automatic chk_m(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                       input logic [63:0] e2, input logic [63:0] e3, input logic [63:0] e4);
    logic [63:0] e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_m%0d", tag, k), cap_m[k], e[k]);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ev = 4'd0; halt = 1'b0; clr = 1'b0; dump_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'({m_valid, w0_valid, w1_valid}), 64'd0);
    chk("rst_idx", 64'(m_idx), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_done", 64'({m_done, w0_done, w1_done}), 64'd0);
`ifdef PERF_OVF_EN
    chk("rst_ovf", 64'({m_ovf, w0_ovf, w1_ovf}), 64'd0);
`endif
    rst = 1'b0;

    // Basic counts: 10 enabled cycles, halt on the 10th.
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 4'b1010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    capture("basic");
    chk_m("basic", 64'd10, 64'd3, 64'd2, 64'd0, 64'd2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'hF, 1'b1, 1'b1);
    chk("done_hold", 64'({m_done, m_valid}), 64'd2);

    // Backpressure at idx 2 while ev/en/halt/clr are all asserted.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0110, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    halt = 1'b0; dump_ready = 1'b1; beats = 0;
    chk("bp_idx0", 64'(m_idx), 64'd0);
    chk("bp_d0", 64'(m_data), 64'd4);
    acc();
    chk("bp_idx1", 64'(m_idx), 64'd1);
    chk("bp_d1", 64'(m_data), 64'd0);
    acc();
    dump_ready = 1'b0; en = 1'b1; ev = 4'hF; halt = 1'b1; clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_idx%0d", i), 64'(m_idx), 64'd2);
      chk($sformatf("bp_hold_d%0d", i), 64'(m_data), 64'd3);
      chk($sformatf("bp_hold_v%0d", i), 64'(m_valid), 64'd1);
      acc();
    end
    en = 1'b0; ev = 4'd0; halt = 1'b0; clr = 1'b0; dump_ready = 1'b1;
    chk("bp_d2", 64'(m_data), 64'd3);
    acc();
    chk("bp_idx3", 64'(m_idx), 64'd3);
    chk("bp_d3", 64'(m_data), 64'd3);
    acc();
    chk("bp_idx4", 64'(m_idx), 64'd4);
    chk("bp_d4", 64'(m_data), 64'd0);
    acc();
    dump_ready = 1'b0;
    chk("bp_done", 64'({m_done, m_valid}), 64'd2);
    chk("bp_beats", 64'(beats), 64'd5);

    // Wrap / saturate: 257 events on ch0, halt on the 257th cycle.
    do_reset();
    for (int i = 0; i < 256; i++) cyc(1'b1, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0);
    capture("wrap");
    chk_m("wrap", 64'd257, 64'd257, 64'd0, 64'd0, 64'd0);
    chk("wrap_w0_cyc", cap_w0[0], 64'd1);
    chk("wrap_w0_ch0", cap_w0[1], 64'd1);
    chk("wrap_w1_cyc", cap_w1[0], 64'd255);
    chk("wrap_w1_ch0", cap_w1[1], 64'd255);
    chk("wrap_w1_ch1", cap_w1[2], 64'd0);
`ifdef PERF_OVF_EN
    chk("wrap_ovf_m", 64'(m_ovf), 64'd0);
    chk("wrap_ovf_w0", 64'(w0_ovf), 64'h3);
    chk("wrap_ovf_w1", 64'(w1_ovf), 64'h3);
`endif

    // clr together with halt at count 6 dumps zeros.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b1);
    capture("clrhalt");
    chk_m("clrhalt", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

    // clr beats a same-cycle event; one more event then halt.
    do_reset();
    for (int i = 0; i < 256; i++) cyc(1'b1, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0, 1'b1);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0);
    capture("clrev");
    chk_m("clrev", 64'd1, 64'd1, 64'd0, 64'd0, 64'd0);
    chk("clrev_w0_ch0", cap_w0[1], 64'd1);
`ifdef PERF_OVF_EN
    chk("clrev_ovf_w0", 64'(w0_ovf), 64'd0);
`endif

    // Disable 4 of 12 cycles (including a halt with en low); events held after halt.
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      cyc(!(i == 3 || i == 4 || i == 7 || i == 8), 4'hF, (i == 4 || i == 12), 1'b0);
    end
    capture("dis");
    chk_m("dis", 64'd8, 64'd8, 64'd8, 64'd8, 64'd8);

    // Reset mid-dump at idx 2, then a fresh run.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0);
    halt = 1'b0; dump_ready = 1'b1;
    chk("rmd_d0", 64'(m_data), 64'd5);
    tick();
    chk("rmd_d1", 64'(m_data), 64'd5);
    tick();
    chk("rmd_idx2", 64'(m_idx), 64'd2);
    rst = 1'b1;
    tick();
    chk("rmd_valid", 64'({m_valid, w0_valid, w1_valid}), 64'd0);
    chk("rmd_idx", 64'(m_idx), 64'd0);
    chk("rmd_data", 64'(m_data), 64'd0);
    chk("rmd_done", 64'(m_done), 64'd0);
    rst = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < 2; i++) cyc(1'b1, 4'b0100, 1'b0, 1'b0);
    cyc(1'b1, 4'b0100, 1'b1, 1'b0);
    capture("fresh");
    chk_m("fresh", 64'd3, 64'd0, 64'd0, 64'd3, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable per-event performance counter bank that sits beside the processor (`proc_hier`) and counts retired-instruction and cache events plus total cycles. On halt it freezes its counters and streams them out over a valid/ready port, so the counts are available in hardware and in synthesis, not only from simulation-side tallies. The bank generalises fixed four-counter instrumentation to a parametrised channel count, counter width and overflow mode.

## Interface
- `NUM_CH`, default 4: number of event channels (1..15).
- `CNT_W`, default 32: counter width in bits (8..64).
- `SAT`, default 0: overflow mode; 0 wraps to zero, 1 saturates at all-ones.
- `IDX_W`, default `$clog2(NUM_CH+1)`: dump index width. It is derived and must not be overridden.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset. It is synchronous and active-high.
- `en` in 1: counting enable; it is low while the core is held in reset.
- `ev` in NUM_CH: per-cycle event strobes; bit i increments channel i.
- `halt` in 1: processor halt strobe.
- `clr` in 1: synchronous clear of all counters; it acts in RUN only.
- `dump_ready` in 1: consumer accepts the current dump beat.
- `dump_valid` out 1: a dump beat is presented.
- `dump_idx` out IDX_W: counter being presented. Index 0 is the cycle counter; index i+1 is channel i.
- `dump_data` out CNT_W: the value of the counter being presented.
- `done` out 1: the dump has completed.
- `ovf` out NUM_CH+1: sticky overflow flags, indexed like `dump_idx`. This port exists only when `PERF_OVF_EN` is defined.

## Operation
- The block has three states: RUN, DUMP and DONE. Reset puts it in RUN.
- **RUN:**
  - The cycle counter increments on every cycle with `en`=1.
  - Channel i increments on every cycle with `en`=1 and `ev[i]`=1.
  - Nothing counts while `en`=0, including on a halt cycle.
- **Clear:**
  - When `clr`=1 in RUN, every counter is 0 next cycle, and that cycle's increments are discarded.
  - `clr` has priority over increments.
  - `clr` is ignored in DUMP and DONE.
- **Entry to DUMP:**
  - `halt`=1 with `en`=1 in RUN moves the block to DUMP next cycle.
  - The halt cycle's own events and cycle are counted.
  - If `clr` is asserted in the same cycle, the counters are cleared and the block still enters DUMP, dumping zeros.
- **Freeze:** in DUMP and DONE all counters are frozen; `ev`, `en` and `halt` are ignored.
- **DUMP:**
  - `dump_valid`=1 and `dump_idx` starts at 0.
  - On `dump_valid` and `dump_ready` the index advances by one.
  - Acceptance at index NUM_CH moves the block to DONE.
- **DONE:** `done`=1 and `dump_valid`=0. The block holds here until `rst`.
- **Width rules:** all counters are CNT_W bits unsigned.
  - SAT=0: all-ones + 1 gives 0.
  - SAT=1: a counter at all-ones stays at all-ones.
- **Reset mid-operation:** `rst` in any state returns the block to RUN with all counters 0, index 0 and flags clear.
- **Reset values of outputs:** `dump_valid`=0, `dump_idx`=0, `dump_data`=0, `done`=0, `ovf`=0.

## Timing
- Counter update latency is 1 cycle: an event at edge n is visible in the counter after edge n.
- `dump_valid` rises on the first edge after the halt cycle.
- `dump_idx` and `dump_data` are registered.
- While `dump_valid`=1 and `dump_ready`=0, `dump_idx` and `dump_data` hold stable.
- With `dump_ready` held high, one beat is accepted per cycle. The full dump takes NUM_CH+1 cycles, and `done` rises on the edge after the last acceptance.
- The block never withdraws `dump_valid` before acceptance.

## Configuration
- The macro is `PERF_OVF_EN`.
- **Defined:**
  - Each counter has a sticky overflow flag. It sets on any increment attempted while the counter is all-ones, in both SAT modes.
  - The flags are cleared by `rst` or by `clr` in RUN.
  - The flags are driven on `ovf` and are frozen in DUMP and DONE.
- **Undefined:** the flag logic and the `ovf` port are absent; counting behaviour is otherwise identical.

## Structure
- Package `perf_pkg` holds:
  - the state enum (RUN, DUMP, DONE);
  - the constants for the min/max legal NUM_CH and CNT_W;
  - a function computing IDX_W.
- Sub-module `perf_counter`: one CNT_W counter with `inc`, `clr`, SAT mode and an optional overflow flag. It is instantiated NUM_CH+1 times.
- The top level holds the FSM, the dump index register and the output mux.

## Test plan
- **Basic counts:** NUM_CH=4, `en`=1. Pulse `ev`=4'b0001 for 3 cycles and `ev`=4'b1010 for 2 cycles, then halt on cycle 10 with `dump_ready`=1. Required dump: idx0=10, idx1=3, idx2=2, idx3=0, idx4=2, followed by `done`=1.
- **Backpressure:** hold `dump_ready`=0 for 5 cycles at idx 2. Required: idx and data stable throughout; idx advances only on the cycle `dump_ready`=1; total beats = 5.
- **Wrap:** CNT_W=8, SAT=0, 257 events on ch0. Required: ch0 = 1, and with `PERF_OVF_EN` defined `ovf[1]`=1. With SAT=1 and the same stimulus, ch0 = 255.
- **clr vs ev:** at count 6, assert `clr` with `ev[0]` in the same cycle. Required: ch0 = 0 after that edge and 1 after the next event; `clr` asserted during DUMP has no effect.
- **Disable and freeze:** `en`=0 for 4 of 12 cycles, with events present throughout. Required: cycle count 8. Events asserted after halt do not alter the dumped values.
- **Reset mid-dump:** assert `rst` at idx 2. Required next cycle: RUN state, `dump_valid`=0, all counters 0. A new run then dumps fresh counts starting from idx 0.
